// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer: sweeps every input vector of a gate under test and checks y against a truth table
module gate_truth_sequencer #(
  parameter int N_IN = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b1110,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            y,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  localparam logic [3:0] SET = 4'(SETTLE);
  state_t state, next;
  logic [3:0] cnt;
  logic mismatch, last;
  // next-state decode plus status flags derived from the current state
  always_comb begin
    next = state;
    mismatch = (state == S_SAMPLE) && (y != EXPECTED[vec]);
    last = &vec;
    busy = (state == S_SETTLE) || (state == S_SAMPLE);
    done = state == S_DONE;
    case (state)
      S_IDLE:   next = start ? S_SETTLE : S_IDLE;
      S_SETTLE: next = (cnt == 4'd1) ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: next = last ? S_DONE : S_SETTLE;
      default:  next = S_IDLE;
    endcase
  end
  // state register with vector walk, settle timer and mismatch bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      vec <= '0;
      cnt <= '0;
      pass <= 1'b0;
      err_count <= '0;
      first_fail <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state <= next;
      case (state)
        S_IDLE: if (start) begin
          vec <= '0;
          cnt <= SET;
          pass <= 1'b0;
          err_count <= '0;
          first_fail <= '0;
          first_fail_valid <= 1'b0;
        end
        S_SETTLE: cnt <= cnt - 4'd1;
        S_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + (N_IN+1)'(1);
            if (!first_fail_valid) begin
              first_fail <= vec;
              first_fail_valid <= 1'b1;
            end
          end
          if (last) pass <= (err_count == '0) && !mismatch;
          else begin
            vec <= vec + N_IN'(1);
            cnt <= SET;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb_gate_truth_sequencer: scoreboard bench driving OR/AND/stuck-0 gates into the sequencer
module tb_gate_truth_sequencer;
  logic clk = 1'b0;
  logic rst, start, y, start3, y3;
  logic [1:0] vec, first_fail;
  logic [2:0] err_count, vec3, first_fail3;
  logic [3:0] err_count3;
  logic busy, done, pass, first_fail_valid;
  logic busy3, done3, pass3, first_fail_valid3;
  int mode;
  int checks = 0;
  int passed = 0;
  typedef struct {logic [2:0] err; logic [1:0] ff; logic ffv; logic pass; int dcyc;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // gate under test: 0 = OR, 1 = AND, other = stuck at 0
  always_comb y = (mode == 0) ? |vec : (mode == 1) ? &vec : 1'b0;
  always_comb y3 = |vec3;

  gate_truth_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .vec(vec), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_fail(first_fail), .first_fail_valid(first_fail_valid)
  );

  gate_truth_sequencer #(.N_IN(3), .EXPECTED(8'hFE), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .y(y3), .vec(vec3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err_count3), .first_fail(first_fail3), .first_fail_valid(first_fail_valid3)
  );

  task automatic push_exp(input int m, input int dcyc);
    exp_t e;
    logic [3:0] ref_tt;
    logic [1:0] v;
    logic g;
    ref_tt = 4'b1110;
    e.err = 0; e.ff = 0; e.ffv = 0; e.dcyc = dcyc;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      g = (m == 0) ? |v : (m == 1) ? &v : 1'b0;
      if (g != ref_tt[i]) begin
        e.err++;
        if (!e.ffv) begin e.ff = v; e.ffv = 1'b1; end
      end
    end
    e.pass = (e.err == 0);
    sb.push_back(e);
  endtask

  task automatic check_done(input int k);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL sb_empty: done at cycle %0d with nothing expected", k);
      return;
    end
    passed++;
    e = sb.pop_front();
    checks++;
    if (k !== e.dcyc) $display("FAIL done_cycle: got %0d want %0d", k, e.dcyc); else passed++;
    checks++;
    if (err_count !== e.err) $display("FAIL err_count: got %0d want %0d", err_count, e.err); else passed++;
    checks++;
    if (first_fail_valid !== e.ffv) $display("FAIL ffv: got %b want %b", first_fail_valid, e.ffv); else passed++;
    checks++;
    if (first_fail !== e.ff) $display("FAIL first_fail: got %0d want %0d", first_fail, e.ff); else passed++;
    checks++;
    if (pass !== e.pass) $display("FAIL pass: got %b want %b", pass, e.pass); else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (vec !== 2'd0) $display("FAIL rst_vec: got %0d want 0", vec); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL rst_pass: got %b want 0", pass); else passed++;
    checks++; if (err_count !== 3'd0) $display("FAIL rst_err: got %0d want 0", err_count); else passed++;
    checks++; if (first_fail_valid !== 1'b0) $display("FAIL rst_ffv: got %b want 0", first_fail_valid); else passed++;
  endtask

  task automatic run_sweep(input int m, input int repulse);
    int busy_n = 0;
    bit got = 0;
    mode = m;
    push_exp(m, 9);
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      start = (k == repulse);
      if (busy) busy_n++;
      if (k <= 8) begin
        checks++;
        if (vec !== 2'((k - 1) / 2)) $display("FAIL vec_step: cycle %0d got %0d want %0d", k, vec, (k - 1) / 2); else passed++;
      end
      if (done) begin got = 1; check_done(k); end
    end
    start = 1'b0;
    checks++; if (!got) $display("FAIL done_timeout: got none want pulse"); else passed++;
    checks++; if (busy_n !== 8) $display("FAIL busy_len: got %0d want 8", busy_n); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL done_width: got %b want 0", done); else passed++;
    checks++; if (vec !== 2'd3) $display("FAIL vec_hold: got %0d want 3", vec); else passed++;
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    mode = 0;
    push_exp(0, 9);
    push_exp(0, 19);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 11) start = 1'b0;
      if (done) begin dones++; check_done(k); end
    end
    checks++; if (dones !== 2) $display("FAIL b2b_count: got %0d want 2", dones); else passed++;
  endtask

  task automatic test_abort;
    int dones = 0;
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (vec !== 2'd0) $display("FAIL abort_vec: got %0d want 0", vec); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
    checks++; if (err_count !== 3'd0) $display("FAIL abort_err: got %0d want 0", err_count); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL abort_pass: got %b want 0", pass); else passed++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones !== 0) $display("FAIL abort_done: got %0d want 0", dones); else passed++;
    run_sweep(0, 0);
  endtask

  task automatic test_wide;
    int busy_n = 0;
    int dcyc = 0;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk) #1 start3 = 1'b0;
    for (int k = 1; k <= 60 && dcyc == 0; k++) begin
      @(negedge clk);
      if (busy3) busy_n++;
      if (k <= 32) begin
        checks++;
        if (vec3 !== 3'((k - 1) / 4)) $display("FAIL wide_vec: cycle %0d got %0d want %0d", k, vec3, (k - 1) / 4); else passed++;
      end
      if (done3) dcyc = k;
    end
    checks++; if (dcyc !== 33) $display("FAIL wide_done: got %0d want 33", dcyc); else passed++;
    checks++; if (busy_n !== 32) $display("FAIL wide_busy: got %0d want 32", busy_n); else passed++;
    checks++; if (pass3 !== 1'b1) $display("FAIL wide_pass: got %b want 1", pass3); else passed++;
    checks++; if (err_count3 !== 4'd0) $display("FAIL wide_err: got %0d want 0", err_count3); else passed++;
    checks++; if (first_fail_valid3 !== 1'b0) $display("FAIL wide_ffv: got %b want 0", first_fail_valid3); else passed++;
  endtask

  initial begin
    test_reset();
    run_sweep(0, 0);
    run_sweep(1, 0);
    run_sweep(2, 0);
    run_sweep(0, 0);
    run_sweep(0, 3);
    test_abort();
    test_back_to_back();
    test_wide();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/gate_truth_sequencer.md
Name: gate_truth_sequencer

Overview:
Sequencer that drives an N-input combinational gate under test (OR, AND, etc.) through every input vector in ascending order. After a programmable settle time it samples the gate output and compares it with a parameterised expected truth table. It counts mismatches and reports pass/fail. It sits beside any gate module as a self-checking controller, replacing hand-written per-row stimulus.

Parameters:
N_IN, 2, number of gate inputs; the sequencer walks 2^N_IN vectors; legal range 1..6
EXPECTED, 4'b1110, expected output per vector; bit i = expected y when vec == i; width 2^N_IN (default = OR table)
SETTLE, 1, cycles vec is held before the sample cycle; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
y  input  1  output of gate under test
vec  output  N_IN  registered input vector driven to the gate
busy  output  1  high in SETTLE and SAMPLE states
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  high when the last completed sweep had zero mismatches; held until the next accepted start
err_count  output  N_IN+1  mismatches in the current/last sweep; max value 2^N_IN, no saturation needed
first_fail  output  N_IN  vector of the first mismatch in the sweep
first_fail_valid  output  1  first_fail holds a captured vector

Behaviour:
- Reset (rst=1 at edge): state IDLE; vec=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0. rst overrides start and any in-flight sweep; no done is produced for an aborted sweep.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at edge T0 -> SETTLE; vec=0; settle counter=SETTLE; busy=1.
  - At the same edge: err_count=0, first_fail=0, first_fail_valid=0, pass=0.
  - Otherwise all outputs hold.
- SETTLE: counter decrements each cycle. On the edge where counter reaches 1 -> SAMPLE. vec remains stable for exactly SETTLE cycles.
- SAMPLE (one cycle), at its closing edge:
  - Compare y against EXPECTED[vec].
  - On mismatch: err_count += 1; if first_fail_valid=0, then first_fail=vec and first_fail_valid=1.
  - If vec == 2^N_IN-1 -> DONE.
  - Otherwise vec += 1, counter=SETTLE, -> SETTLE.
- DONE (one cycle): done=1, busy=0. pass=1 iff the final err_count (including the last sample) == 0. Pass is computed with the last-sample update folded in, so it is not a cycle stale. Next edge -> IDLE and done=0.
- vec holds 2^N_IN-1 after the sweep until the next start.
- Latency: done is high in the cycle following edge T0 + 2^N_IN*(SETTLE+1). busy is high for exactly 2^N_IN*(SETTLE+1) cycles.
- start is ignored while busy or in DONE. start held high continuously produces back-to-back sweeps, each separated by one DONE cycle and one IDLE-accept edge.
- vec increments without wrap; the sweep ends at the all-ones vector.
- y is sampled only in SAMPLE; glitches during SETTLE have no effect.

Test Plan:
1. Reset then idle 5 cycles -> vec=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0.
2. Defaults, DUT = OR gate, 1-cycle start pulse at T0 -> vec steps 00,01,10,11 every 2 cycles; busy high 8 cycles; done pulse cycle 9; pass=1, err_count=0, first_fail_valid=0.
3. DUT replaced by AND gate -> mismatches at 01 and 10; err_count=2, first_fail=01, first_fail_valid=1, pass=0.
4. y tied to 0 -> err_count=3, first_fail=01, pass=0. Then start again with the OR gate -> counters cleared at accept; pass=1, err_count=0.
5. Start re-pulsed at cycle 3 of a sweep -> ignored; done still at cycle 9. Then rst asserted at cycle 5 of a new sweep -> all outputs at reset values next cycle, no done; a following start completes normally.
6. SETTLE=3, N_IN=3, EXPECTED=8'hFE (3-input OR) -> busy 32 cycles; each vec held 4 cycles; pass=1.
